// File: rtl/sipo_frame_pkg.sv
// Shared types and line-level constants for the self-timed framed serial receiver.
package sipo_frame_pkg;

  typedef enum logic {IDLE, SHIFT} rx_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/rx_hold_stage.sv
// One-entry valid/ready holding register; a word arriving while full and not draining is dropped.
module rx_hold_stage
  import sipo_frame_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         drop,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready
);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;
  logic         xfer;
  logic         capture;

  always_comb begin
    xfer    = valid_q && out_ready;
    capture = in_valid && (!valid_q || xfer);
    drop    = in_valid && valid_q && !xfer;
    valid_d = valid_q;
    data_d  = data_q;
    // data_q is left alone on a plain drain so the last word stays visible
    if (capture) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Framed serial receiver: start bit, then N data bits MSB first, word delivered through a
// one-entry holding register on the edge that samples the last data bit.
module sipo_frame_rx
  import sipo_frame_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         busy,
  output logic         overrun,
  input  logic         overrun_clr
);

  localparam int CW = $clog2(N);

  rx_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-2:0] shift_q, shift_d;
  logic         ovr_q, ovr_d;
  logic [N-1:0] word;
  logic         word_vld;
  logic         drop;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    word     = {shift_q, serial_in};
    word_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (serial_in == START_BIT) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        shift_d = word[N-2:0];
        cnt_d   = cnt_q + CW'(1);
        // A 1 seen here is always data; the next start bit is only looked for from IDLE
        if (cnt_q == CW'(N - 1)) begin
          word_vld = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ovr_q   <= ovr_d;
    end
  end

  rx_hold_stage #(.N(N)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (word_vld),
    .in_data   (word),
    .drop      (drop),
    .out_valid (data_valid),
    .out_data  (data_out),
    .out_ready (data_ready)
  );

  assign busy    = (state_q == SHIFT);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: directed frames from the test plan plus randomized traffic,
// every cycle compared against a frame-level reference model.
module tb_sipo_frame_rx;
  import sipo_frame_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         serial_in;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         busy;
  logic         overrun;
  logic         overrun_clr;

  sipo_frame_rx #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bits remaining in the current frame, word built arithmetically,
  // holding register as a queue of capacity one.
  int           m_left;
  logic [N-1:0] m_acc;
  logic [N-1:0] m_hold[$];
  logic [N-1:0] m_last;
  bit           m_ovr;
  bit           rand_mode = 0;
  logic [N-1:0] acc_log[$];

  task automatic model_reset();
    m_left = 0;
    m_acc  = '0;
    m_hold.delete();
    m_last = '0;
    m_ovr  = 0;
  endtask

  task automatic model_edge();
    bit           done;
    bit           xfer;
    bit           dropped;
    logic [N-1:0] w;
    done    = 0;
    dropped = 0;
    w       = '0;
    xfer    = (m_hold.size() != 0) && (data_ready === 1'b1);
    if (m_left == 0) begin
      if (serial_in === 1'b1) begin
        m_left = N;
        m_acc  = '0;
      end
    end else begin
      m_acc  = (m_acc << 1) | N'(serial_in);
      m_left = m_left - 1;
      if (m_left == 0) begin
        done = 1;
        w    = m_acc;
      end
    end
    if (xfer) void'(m_hold.pop_front());
    if (done) begin
      if (m_hold.size() == 0) begin
        m_hold.push_back(w);
        m_last = w;
      end else begin
        dropped = 1;
      end
    end
    if (dropped) m_ovr = 1;
    else if (overrun_clr === 1'b1) m_ovr = 0;
  endtask

  // One clock: optional random handshake, log consumer accepts, advance model, compare.
  task automatic tick();
    if (rand_mode) begin
      data_ready  = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 7) == 0);
    end
    if (data_valid === 1'b1 && data_ready === 1'b1) acc_log.push_back(data_out);
    @(posedge clk);
    if (reset === 1'b1) model_reset();
    else model_edge();
    #1;
    check("valid", 64'(data_valid), 64'(m_hold.size() != 0));
    check("data",  64'(data_out),   64'(m_last));
    check("busy",  64'(busy),       64'(m_left != 0));
    check("ovr",   64'(overrun),    64'(m_ovr));
  endtask

  // Start bit, then N bits MSB first; first_valid is the data-bit index after which
  // data_valid was first seen high (0 if never).
  task automatic send_word(input logic [N-1:0] w, input bit ready_last, output int first_valid);
    logic [N-1:0] v;
    v = w;
    first_valid = 0;
    serial_in = START_BIT;
    tick();
    for (int i = N - 1; i >= 0; i--) begin
      serial_in = v[i];
      if (i == 0 && ready_last) data_ready = 1'b1;
      tick();
      if (first_valid == 0 && data_valid === 1'b1) first_valid = N - i;
    end
    serial_in = IDLE_LEVEL;
  endtask

  task automatic idle(input int n);
    serial_in = IDLE_LEVEL;
    for (int i = 0; i < n; i++) tick();
  endtask

  int           fv;
  logic [N-1:0] rw;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] pat;

  initial begin
    reset       = 1'b1;
    serial_in   = IDLE_LEVEL;
    data_ready  = 1'b0;
    overrun_clr = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_data",  64'(data_out),   64'd0);
    check("rst_busy",  64'(busy),       64'd0);
    check("rst_ovr",   64'(overrun),    64'd0);
    tick();
    tick();
    reset = 1'b0;

    idle(20);
    check("idle_valid", 64'(data_valid), 64'd0);
    check("idle_busy",  64'(busy),       64'd0);
    check("idle_data",  64'(data_out),   64'd0);

    // Single frame with a ready consumer
    data_ready = 1'b1;
    acc_log.delete();
    send_word(32'hDEADBEEF, 0, fv);
    check("first_valid_edge", 64'(fv), 64'(N));
    check("beef_data", 64'(data_out), 64'hDEADBEEF);
    check("beef_busy", 64'(busy), 64'd0);
    tick();
    check("beef_consumed", 64'(data_valid), 64'd0);
    check("beef_log_n", 64'(acc_log.size()), 64'd1);
    if (acc_log.size() > 0) check("beef_log", 64'(acc_log[0]), 64'hDEADBEEF);

    // Back-to-back frames, N+1 cycle period
    acc_log.delete();
    send_word(32'h00000000, 0, fv);
    send_word(32'hFFFFFFFF, 0, fv);
    send_word(32'h80000000, 0, fv);
    idle(2);
    check("b2b_n", 64'(acc_log.size()), 64'd3);
    if (acc_log.size() == 3) begin
      check("b2b_0", 64'(acc_log[0]), 64'h00000000);
      check("b2b_1", 64'(acc_log[1]), 64'hFFFFFFFF);
      check("b2b_2", 64'(acc_log[2]), 64'h80000000);
    end
    check("b2b_ovr", 64'(overrun), 64'd0);

    // Overrun with a stalled consumer
    data_ready = 1'b0;
    send_word(32'h12345678, 0, fv);
    send_word(32'h9ABCDEF0, 0, fv);
    check("ovr_data", 64'(data_out), 64'h12345678);
    check("ovr_set",  64'(overrun),  64'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_clr", 64'(overrun), 64'd0);
    acc_log.delete();
    data_ready = 1'b1;
    idle(4);
    check("ovr_log_n", 64'(acc_log.size()), 64'd1);
    if (acc_log.size() > 0) check("ovr_log", 64'(acc_log[0]), 64'h12345678);

    // Drain and refill on the same edge
    data_ready = 1'b0;
    send_word(32'hAAAAAAAA, 0, fv);
    idle(2);
    acc_log.delete();
    send_word(32'h55555555, 1, fv);
    data_ready = 1'b0;
    check("swap_valid", 64'(data_valid), 64'd1);
    check("swap_data",  64'(data_out),   64'h55555555);
    check("swap_ovr",   64'(overrun),    64'd0);
    check("swap_log_n", 64'(acc_log.size()), 64'd1);
    if (acc_log.size() > 0) check("swap_log", 64'(acc_log[0]), 64'hAAAAAAAA);
    data_ready = 1'b1;
    idle(3);

    // Reset in the middle of a frame, asserted between clock edges
    pat = 32'hF0F0F0F0;
    serial_in = START_BIT;
    tick();
    for (int i = N - 1; i > N - 11; i--) begin
      serial_in = pat[i];
      tick();
    end
    check("mid_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_valid", 64'(data_valid), 64'd0);
    check("mid_rst_busy",  64'(busy),       64'd0);
    check("mid_rst_data",  64'(data_out),   64'd0);
    check("mid_rst_ovr",   64'(overrun),    64'd0);
    serial_in = IDLE_LEVEL;
    tick();
    reset = 1'b0;
    idle(40);
    acc_log.delete();
    send_word(32'h00000001, 0, fv);
    check("post_rst_data", 64'(data_out), 64'h00000001);
    tick();
    check("post_rst_log_n", 64'(acc_log.size()), 64'd1);

    // Randomized traffic: random words, gaps, handshake and clears
    rand_mode = 1;
    for (int f = 0; f < 150; f++) begin
      rw = $urandom();
      if ($urandom_range(0, 9) == 0) rw = '0;
      if ($urandom_range(0, 9) == 0) rw = '1;
      send_word(rw, 0, fv);
      idle($urandom_range(0, 3));
    end
    rand_mode = 0;
    overrun_clr = 1'b0;
    data_ready  = 1'b1;
    idle(4);
    check("end_valid", 64'(data_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
